// File: rtl/uart_tx_drain_if.sv
// Upstream FIFO pop port plus serial-line status for uart_tx_drain.
// master = FIFO/line side, slave = the transmitter.
interface uart_tx_drain_if;
  logic [7:0] fifo_data;
  logic       fifo_not_empty;
  logic       fifo_read_strobe;
  logic       tx;
  logic       busy;

  modport master (
    output fifo_data,
    output fifo_not_empty,
    input  fifo_read_strobe,
    input  tx,
    input  busy
  );

  modport slave (
    input  fifo_data,
    input  fifo_not_empty,
    output fifo_read_strobe,
    output tx,
    output busy
  );
endinterface

// File: rtl/uart_tx_drain.sv
// Drains a FIFO onto a UART line: 8N1, or 8E1 when UART_TX_PARITY_EN is defined; tx falls the cycle after the pop edge.
// One registered pop strobe per frame; FIFO inputs are ignored while a frame is in flight, one idle cycle between frames.
module uart_tx_drain #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
  input logic            clk,
  input logic            reset,
  uart_tx_drain_if.slave tx_if
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [2:0] LAST_BIT = 3'd7;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic baud_done;
  assign baud_done = (baud_q == CLKS_PER_BIT - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d is the line level for the state being entered, so tx stays registered
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    strobe_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (tx_if.fifo_not_empty) begin
          shift_d  = tx_if.fifo_data;
          bit_d    = '0;
          strobe_d = 1'b1;
          tx_d     = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.fifo_data;
`endif
        end
      end

      START: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign tx_if.fifo_read_strobe = strobe_q;
  assign tx_if.tx               = tx_q;
  assign tx_if.busy             = busy_q;

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16'd434, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock, all state on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port fifo_data  input  8  head-of-FIFO byte, valid while fifo_not_empty is high.
REQ-005 SHALL have port fifo_not_empty  input  1  upstream FIFO holds at least one byte.
REQ-006 SHALL have port fifo_read_strobe  output  1  registered pop request; upstream pops on its rising edge.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-010 In IDLE with fifo_not_empty high at a clock edge, SHALL latch fifo_data into an 8-bit shift register, drive fifo_read_strobe high for exactly one cycle, and enter START.
REQ-011 fifo_read_strobe SHALL be low in every cycle except the one after a REQ-010 edge, so each rising edge pops exactly one byte.
REQ-012 tx SHALL be registered: 0 in START, shift-register LSB in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-013 Each of START, DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a 16-bit baud counter counting 0..CLKS_PER_BIT-1 and cleared on every state entry.
REQ-014 DATA SHALL send 8 bits LSB-first, using a 3-bit bit counter and a right-shift per bit period; after bit 7 SHALL go to PARITY (macro defined) or STOP.
REQ-015 At the end of STOP SHALL return to IDLE; if fifo_not_empty is high on that IDLE cycle, REQ-010 applies, giving exactly one idle-high cycle between frames.
REQ-016 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity); from the REQ-010 edge, tx SHALL fall on the next cycle.
REQ-017 fifo_data and fifo_not_empty SHALL be ignored outside IDLE; changes mid-frame SHALL not affect the byte being sent.
REQ-018 With fifo_not_empty low in IDLE, the block SHALL hold tx=1, busy=0, fifo_read_strobe=0 indefinitely.
REQ-019 busy SHALL rise with fifo_read_strobe and fall on the cycle state re-enters IDLE.

Reset
REQ-020 Asserting reset SHALL immediately force state=IDLE, tx=1, busy=0, fifo_read_strobe=0, both counters and shift register to 0, independent of clk.
REQ-021 Reset mid-frame SHALL abort the frame with no further FIFO pop; the aborted byte is lost.
REQ-022 After reset deasserts, the first REQ-010 edge SHALL be no earlier than the first rising clk edge with reset low.

Configuration
REQ-023 Macro UART_TX_PARITY_EN SHALL control parity: defined -> PARITY state sends even parity (XOR of 8 data bits) between DATA and STOP; undefined -> PARITY state, its logic and the parity register are absent and DATA goes straight to STOP.

Verification (CLKS_PER_BIT=4)
REQ-024 Byte 0x55 present, macro off -> tx 0,1,0,1,0,1,0,1,0,1 each held 4 cycles (40 cycles), one fifo_read_strobe pulse, busy high 40 cycles.
REQ-025 Byte 0xA3 with macro on -> tx 0, 1,1,0,0,0,1,0,1, parity 0, stop 1; 44 cycles total.
REQ-026 Three bytes 0x01,0x02,0x03 queued -> three frames, exactly one idle-high cycle between each, exactly three strobe pulses, each one cycle wide.
REQ-027 reset asserted at cycle 13 of a 0xFF frame -> tx=1, busy=0 within the same cycle; no strobe until fifo_not_empty seen after reset release.
REQ-028 fifo_data changed 0x11->0xEE mid-frame -> transmitted byte remains 0x11.
REQ-029 fifo_not_empty held low 200 cycles -> tx=1, busy=0, fifo_read_strobe=0 throughout.
